uart_tx_arbiter: RTL

Shares one UART transmit line between NUM_REQ requesters, such as the LED status reporter, the command-echo path and debug taps, using round-robin arbitration with packet locking. It sits between the on-chip byte sources and the board TX pin, and it replaces the direct RX-to-TX loopback wiring. A built-in 8N1 serializer produces the line waveform, so each multi-byte packet leaves the pin uninterrupted.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_serializer.sv | 72 +++++++
 rtl/uart_tx_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter slice.
//   FRAME_BITS  : bits per 8N1 frame (start + 8 data + stop)
//   arb_state_t : arbiter FSM states
//   bit_period(): CLK cycles per serial bit, truncated
package uart_pkg;

  localparam int unsigned FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } arb_state_t;

  function automatic int unsigned bit_period(input int unsigned clk_hz,
                                             input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: start bit (0), DATA LSB first, one stop bit (1); each bit
// lasts BIT_PERIOD cycles.
//   CLK    : system clock, posedge
//   RESETN : asynchronous active-low reset; TX returns high immediately
//   START  : accepted only while idle; DATA is captured on the same edge and
//            TX drops to the start bit right after it
//   DATA   : byte to send
//   TX     : serial line, idles high
//   DONE   : one-cycle pulse during the last cycle of the stop bit
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned BIT_PERIOD = 1250
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       START,
  input  logic [7:0] DATA,
  output logic       TX,
  output logic       DONE
);

  localparam int unsigned BAUD_W = (BIT_PERIOD > 2) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_PERIOD - 1);
  localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 1);

  logic              active;
  logic [3:0]        bit_cnt;
  logic [BAUD_W-1:0] baud_cnt;
  logic [8:0]        shreg;
  logic              tx_q;
  logic              bit_end;

  assign bit_end = active && (baud_cnt == BAUD_LAST);
  // Combinational so the arbiter can leave SEND on the very edge that ends
  // the stop bit; this is what makes the inter-frame gap a single cycle.
  assign DONE    = bit_end && (bit_cnt == BIT_LAST);
  assign TX      = tx_q;

  // bit_cnt: 0 = start, 1..8 = data, 9 = stop. shreg holds the remaining
  // data bits with the stop bit parked above them.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      active   <= 1'b0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      shreg    <= '0;
      tx_q     <= 1'b1;
    end else if (!active) begin
      if (START) begin
        active   <= 1'b1;
        tx_q     <= 1'b0;
        shreg    <= {1'b1, DATA};
        bit_cnt  <= '0;
        baud_cnt <= '0;
      end
    end else if (bit_end) begin
      baud_cnt <= '0;
      if (DONE) begin
        active <= 1'b0;
        tx_q   <= 1'b1;
      end else begin
        tx_q    <= shreg[0];
        shreg   <= {1'b1, shreg[8:1]};
        bit_cnt <= bit_cnt + 4'd1;
      end
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet locking in front of one 8N1 TX line.
//   CLK       : system clock, posedge
//   RESETN    : asynchronous active-low reset
//   REQ_VALID : per-requester byte valid
//   REQ_DATA  : requester i byte at [8i+7:8i]
//   REQ_LAST  : byte closes the packet
//   REQ_READY : handshake, equals GRANT only while in LOAD
//   GRANT     : one-hot line owner, zero when idle
//   BUSY      : arbiter not idle
//   ABORT     : one-cycle pulse when a stalled packet loses its lock
//   TX        : serial output, idles high
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned BAUD_RATE     = 9600,
  parameter int unsigned CLOCK_FREQ_HZ = 12000000,
  parameter int unsigned LOCK_TIMEOUT  = 65535
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  input  logic [NUM_REQ-1:0]   REQ_VALID,
  input  logic [8*NUM_REQ-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]   REQ_LAST,
  output logic [NUM_REQ-1:0]   REQ_READY,
  output logic [NUM_REQ-1:0]   GRANT,
  output logic                 BUSY,
  output logic                 ABORT,
  output logic                 TX
);

  localparam int unsigned BIT_PERIOD = bit_period(CLOCK_FREQ_HZ, BAUD_RATE);
  localparam int unsigned PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TO_W       = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam bit          TO_EN      = (LOCK_TIMEOUT > 0);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);
  localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE    = NUM_REQ'(1);

  if (BIT_PERIOD < 2) begin : g_bad_baud
    $error("uart_tx_arbiter: CLOCK_FREQ_HZ / BAUD_RATE must be at least 2");
  end
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ must be within 2..8");
  end

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   gidx_q, gidx_d;
  logic               last_q, last_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               abort_q, abort_d;

  logic               sel_found;
  logic [PTR_W-1:0]   sel_idx;
  logic [PTR_W-1:0]   cand_idx;
  logic               valid_g;
  logic               last_g;
  logic               ser_start;
  logic [7:0]         ser_data;
  logic               ser_done;

  // First valid requester strictly after ptr, wrapping; ptr itself is
  // checked last so the previous owner has the lowest priority.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand_idx  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand_idx = PTR_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!sel_found && REQ_VALID[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    ser_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gidx_q == PTR_W'(i)) ser_data = REQ_DATA[8*i +: 8];
    end
  end

  assign valid_g = |(REQ_VALID & grant_q);
  assign last_g  = |(REQ_LAST & grant_q);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    last_d    = last_q;
    to_cnt_d  = to_cnt_q;
    abort_d   = 1'b0;
    ser_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          grant_d = ONE << sel_idx;
          gidx_d  = sel_idx;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (valid_g) begin
          // The byte itself is captured by the serializer on this edge.
          last_d    = last_g;
          ser_start = 1'b1;
          to_cnt_d  = '0;
          state_d   = SEND;
        end else if (TO_EN) begin
          if (to_cnt_q == TO_LAST) begin
            abort_d  = 1'b1;
            ptr_d    = gidx_q;
            grant_d  = '0;
            to_cnt_d = '0;
            state_d  = IDLE;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
      end
      SEND: begin
        if (ser_done) begin
          if (last_q) begin
            ptr_d   = gidx_q;
            grant_d = '0;
            state_d = IDLE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      ptr_q    <= PTR_INIT;
      gidx_q   <= '0;
      last_q   <= 1'b0;
      to_cnt_q <= '0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      gidx_q   <= gidx_d;
      last_q   <= last_d;
      to_cnt_q <= to_cnt_d;
      abort_q  <= abort_d;
    end
  end

  assign GRANT     = grant_q;
  assign REQ_READY = (state_q == LOAD) ? grant_q : '0;
  assign BUSY      = (state_q != IDLE);
  assign ABORT     = abort_q;

  uart_tx_serializer #(
    .BIT_PERIOD (BIT_PERIOD)
  ) u_ser (
    .CLK    (CLK),
    .RESETN (RESETN),
    .START  (ser_start),
    .DATA   (ser_data),
    .TX     (TX),
    .DONE   (ser_done)
  );

endmodule
